// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-side bundle for the data-memory arbiter.
// The slave modport is the arbiter; master is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c_req_valid, c_req_ready, c_req_we, c_req_lock;
  logic [2:0]        c_req_ctrl;
  logic [ADDR_W-1:0] c_req_addr;
  logic [DATA_W-1:0] c_req_wdata;
  logic              c_rsp_valid, c_rsp_err;
  logic [DATA_W-1:0] c_rsp_rdata;

  logic              d_req_valid, d_req_ready, d_req_we, d_req_lock;
  logic [2:0]        d_req_ctrl;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_rsp_valid, d_rsp_err;
  logic [DATA_W-1:0] d_rsp_rdata;

  logic              dm_wr;
  logic [2:0]        dm_ctrl;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  modport slave (
    input  c_req_valid, c_req_we, c_req_lock, c_req_ctrl, c_req_addr, c_req_wdata,
    output c_req_ready, c_rsp_valid, c_rsp_err, c_rsp_rdata,
    input  d_req_valid, d_req_we, d_req_lock, d_req_ctrl, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    output dm_wr, dm_ctrl, dm_addr, dm_wdata,
    input  dm_rdata
  );

  modport master (
    output c_req_valid, c_req_we, c_req_lock, c_req_ctrl, c_req_addr, c_req_wdata,
    input  c_req_ready, c_rsp_valid, c_rsp_err, c_rsp_rdata,
    output d_req_valid, d_req_we, d_req_lock, d_req_ctrl, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_rdata,
    input  dm_wr, dm_ctrl, dm_addr, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin/lockable arbiter between core LSU (C) and loader/DMA (D) for the data memory.
// Optional misalignment trap: define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);
  localparam logic C = 1'b0;
  localparam logic D = 1'b1;
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  typedef enum logic [1:0] {RR, LOCK_C, LOCK_D} state_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              lock;
    logic [2:0]        ctrl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t [1:0]   req;
  logic [1:0]   mis, gnt;
  state_t       state, state_n;
  logic         prio, prio_n;
  logic [3:0]   hold_cnt, hold_n;
  logic         win, wsel;
  req_t         wreq;

  logic [1:0]             rsp_vld, rsp_err;
  logic [1:0][DATA_W-1:0] rsp_rdata;

  assign req[C] = '{bus.c_req_valid, bus.c_req_we, bus.c_req_lock,
                    bus.c_req_ctrl, bus.c_req_addr, bus.c_req_wdata};
  assign req[D] = '{bus.d_req_valid, bus.d_req_we, bus.d_req_lock,
                    bus.d_req_ctrl, bus.d_req_addr, bus.d_req_wdata};

  for (genvar i = 0; i < 2; i++) begin : g_req
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign mis[i] = ((req[i].ctrl[1:0] == 2'b01) && req[i].addr[0]) ||
                    ((req[i].ctrl == 3'b010) && (req[i].addr[1:0] != 2'b00));
`else
    assign mis[i] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RR;
      prio     <= C;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      prio     <= prio_n;
      hold_cnt <= hold_n;
    end
  end

  // hold_cnt counts every cycle in a lock state, idle or not, so an idle owner still times out
  always_comb begin
    gnt     = '0;
    state_n = state;
    prio_n  = prio;
    hold_n  = hold_cnt;
    case (state)
      RR: begin
        if (req[C].valid && (!req[D].valid || prio == C)) gnt[C] = 1'b1;
        else if (req[D].valid)                            gnt[D] = 1'b1;
        if (gnt != 2'b00) prio_n = gnt[C] ? D : C;
        if ((gnt[C] && req[C].lock) || (gnt[D] && req[D].lock)) begin
          state_n = gnt[C] ? LOCK_C : LOCK_D;
          hold_n  = '0;
        end
      end
      LOCK_C: begin
        gnt[C] = req[C].valid;
        hold_n = hold_cnt + 4'd1;
        if ((gnt[C] && !req[C].lock) || hold_cnt == HOLD_LAST) begin
          state_n = RR;
          prio_n  = D;
          hold_n  = '0;
        end
      end
      LOCK_D: begin
        gnt[D] = req[D].valid;
        hold_n = hold_cnt + 4'd1;
        if ((gnt[D] && !req[D].lock) || hold_cnt == HOLD_LAST) begin
          state_n = RR;
          prio_n  = C;
          hold_n  = '0;
        end
      end
      default: state_n = RR;
    endcase
    if (rst) gnt = '0;
  end

  assign win  = |gnt;
  assign wsel = gnt[D];
  assign wreq = req[wsel];

  assign bus.c_req_ready = gnt[C];
  assign bus.d_req_ready = gnt[D];
  assign bus.dm_wr    = win & wreq.valid & wreq.we & ~mis[wsel];
  assign bus.dm_ctrl  = win ? wreq.ctrl  : '0;
  assign bus.dm_addr  = win ? wreq.addr  : '0;
  assign bus.dm_wdata = win ? wreq.wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld   <= '0;
      rsp_err   <= '0;
      rsp_rdata <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rsp_vld[i]   <= gnt[i];
        rsp_err[i]   <= gnt[i] & mis[i];
        rsp_rdata[i] <= (gnt[i] && !req[i].we && !mis[i]) ? bus.dm_rdata : '0;
      end
    end
  end

  // Gating with rst drops a response that was registered just before reset rose
  assign bus.c_rsp_valid = rsp_vld[C] & ~rst;
  assign bus.d_rsp_valid = rsp_vld[D] & ~rst;
  assign bus.c_rsp_err   = rsp_err[C] & ~rst;
  assign bus.d_rsp_err   = rsp_err[D] & ~rst;
  assign bus.c_rsp_rdata = rsp_rdata[C];
  assign bus.d_rsp_rdata = rsp_rdata[D];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:255];
  logic [7:0]  ma;
  logic [31:0] mw;

  always_comb begin
    ma = bus.dm_addr[7:0];
    mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    case (bus.dm_ctrl)
      3'b000:  bus.dm_rdata = {{24{mw[7]}}, mw[7:0]};
      3'b001:  bus.dm_rdata = {{16{mw[15]}}, mw[15:0]};
      3'b100:  bus.dm_rdata = {24'h0, mw[7:0]};
      3'b101:  bus.dm_rdata = {16'h0, mw[15:0]};
      default: bus.dm_rdata = mw;
    endcase
  end

  always @(posedge clk)
    if (bus.dm_wr) begin
      mem[bus.dm_addr[7:0]] <= bus.dm_wdata[7:0];
      if (bus.dm_ctrl[1:0] != 2'b00) mem[bus.dm_addr[7:0] + 8'd1] <= bus.dm_wdata[15:8];
      if (bus.dm_ctrl[1:0] == 2'b10) begin
        mem[bus.dm_addr[7:0] + 8'd2] <= bus.dm_wdata[23:16];
        mem[bus.dm_addr[7:0] + 8'd3] <= bus.dm_wdata[31:24];
      end
    end

  task automatic set_c(input logic v, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    bus.c_req_valid = v; bus.c_req_we = we; bus.c_req_ctrl = ctrl;
    bus.c_req_addr = addr; bus.c_req_wdata = wdata; bus.c_req_lock = lock;
  endtask

  task automatic set_d(input logic v, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic lock);
    bus.d_req_valid = v; bus.d_req_we = we; bus.d_req_ctrl = ctrl;
    bus.d_req_addr = addr; bus.d_req_wdata = wdata; bus.d_req_lock = lock;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_c(0, 0, 3'b010, 0, 0, 0);
    set_d(0, 0, 3'b010, 0, 0, 0);
    edge1();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_c(1, 1, 3'b010, 32'h20, 32'h5A5A5A5A, 0);
    set_d(1, 1, 3'b010, 32'h24, 32'hA5A5A5A5, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b0) begin failures++; $display("FAIL rst_c_ready act=%0b exp=0", bus.c_req_ready); end
    checks++; if (bus.d_req_ready !== 1'b0) begin failures++; $display("FAIL rst_d_ready act=%0b exp=0", bus.d_req_ready); end
    checks++; if (bus.dm_wr !== 1'b0) begin failures++; $display("FAIL rst_dm_wr act=%0b exp=0", bus.dm_wr); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid act=%0b%0b exp=00", bus.c_rsp_valid, bus.d_rsp_valid); end
    checks++; if (bus.c_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata act=%h exp=0", bus.c_rsp_rdata); end
  endtask

  task automatic test_store_load();
    do_reset();
    set_c(1, 1, 3'b010, 32'h100, 32'h11111111, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1) begin failures++; $display("FAIL sl_sw_ready act=%0b exp=1", bus.c_req_ready); end
    checks++; if (bus.d_req_ready !== 1'b0) begin failures++; $display("FAIL sl_sw_d_ready act=%0b exp=0", bus.d_req_ready); end
    checks++; if (bus.dm_wr !== 1'b1 || bus.dm_addr !== 32'h100) begin failures++; $display("FAIL sl_sw_mem act=%0b/%h exp=1/100", bus.dm_wr, bus.dm_addr); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b1 || bus.c_rsp_err !== 1'b0) begin failures++; $display("FAIL sl_sw_rsp act=%0b/%0b exp=1/0", bus.c_rsp_valid, bus.c_rsp_err); end
    set_c(1, 0, 3'b010, 32'h100, 32'h0, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1 || bus.d_req_ready !== 1'b0 || bus.dm_wr !== 1'b0) begin failures++; $display("FAIL sl_lw_grant act=%0b%0b%0b exp=100", bus.c_req_ready, bus.d_req_ready, bus.dm_wr); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b1) begin failures++; $display("FAIL sl_lw_valid act=%0b exp=1", bus.c_rsp_valid); end
    checks++; if (bus.c_rsp_rdata !== 32'h11111111) begin failures++; $display("FAIL sl_lw_rdata act=%h exp=11111111", bus.c_rsp_rdata); end
    set_c(0, 0, 3'b010, 0, 0, 0);
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b0) begin failures++; $display("FAIL sl_pulse_end act=%0b exp=0", bus.c_rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic expd;
    do_reset();
    set_c(1, 0, 3'b010, 32'h100, 0, 0);
    set_d(1, 0, 3'b010, 32'h104, 0, 0);
    for (int k = 0; k < 4; k++) begin
      expd = k[0];
      @(negedge clk);
      checks++; if (bus.c_req_ready !== ~expd || bus.d_req_ready !== expd) begin failures++; $display("FAIL rr_grant%0d act=%0b%0b exp=%0b%0b", k, bus.c_req_ready, bus.d_req_ready, ~expd, expd); end
      edge1();
      checks++; if (bus.c_rsp_valid !== ~expd || bus.d_rsp_valid !== expd) begin failures++; $display("FAIL rr_rsp%0d act=%0b%0b exp=%0b%0b", k, bus.c_rsp_valid, bus.d_rsp_valid, ~expd, expd); end
    end
  endtask

  task automatic test_lock();
    do_reset();
    set_d(1, 1, 3'b000, 32'h30, 32'hFF, 0);
    edge1();
    set_d(0, 0, 3'b010, 0, 0, 0);
    set_c(1, 0, 3'b010, 32'h40, 0, 0);
    edge1();
    set_d(1, 0, 3'b000, 32'h30, 0, 1);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b0 || bus.d_req_ready !== 1'b1) begin failures++; $display("FAIL lk_c1_grant act=%0b%0b exp=01", bus.c_req_ready, bus.d_req_ready); end
    edge1();
    checks++; if (bus.d_rsp_valid !== 1'b1 || bus.d_rsp_rdata !== 32'hFFFFFFFF) begin failures++; $display("FAIL lk_lb_rsp act=%0b/%h exp=1/ffffffff", bus.d_rsp_valid, bus.d_rsp_rdata); end
    checks++; if (bus.c_rsp_valid !== 1'b0) begin failures++; $display("FAIL lk_c1_crsp act=%0b exp=0", bus.c_rsp_valid); end
    set_d(1, 1, 3'b000, 32'h30, 32'h7F, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b0 || bus.d_req_ready !== 1'b1 || bus.dm_wr !== 1'b1) begin failures++; $display("FAIL lk_c2_grant act=%0b%0b%0b exp=011", bus.c_req_ready, bus.d_req_ready, bus.dm_wr); end
    edge1();
    set_d(0, 0, 3'b010, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1) begin failures++; $display("FAIL lk_c3_cgrant act=%0b exp=1", bus.c_req_ready); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b1) begin failures++; $display("FAIL lk_c3_crsp act=%0b exp=1", bus.c_rsp_valid); end
    set_c(0, 0, 3'b010, 0, 0, 0);
    set_d(1, 0, 3'b100, 32'h30, 0, 0);
    edge1();
    checks++; if (bus.d_rsp_rdata !== 32'h0000007F) begin failures++; $display("FAIL lk_sb_readback act=%h exp=0000007f", bus.d_rsp_rdata); end
  endtask

  task automatic test_forced_release();
    do_reset();
    set_c(1, 0, 3'b010, 32'h40, 0, 0);
    edge1();
    set_d(1, 0, 3'b010, 32'h44, 0, 1);
    @(negedge clk);
    checks++; if (bus.d_req_ready !== 1'b1 || bus.c_req_ready !== 1'b0) begin failures++; $display("FAIL fr_lock_grant act=%0b%0b exp=01", bus.c_req_ready, bus.d_req_ready); end
    edge1();
    set_d(0, 0, 3'b010, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (bus.c_req_ready !== 1'b0) begin failures++; $display("FAIL fr_held%0d act=%0b exp=0", k, bus.c_req_ready); end
      edge1();
    end
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1) begin failures++; $display("FAIL fr_release act=%0b exp=1", bus.c_req_ready); end
    edge1();
    set_c(0, 0, 3'b010, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_c(1, 1, 3'b010, 32'h10, 32'h0000ABCD, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1) begin failures++; $display("FAIL rm_sw_ready act=%0b exp=1", bus.c_req_ready); end
    edge1();
    rst = 1'b1;
    set_c(1, 1, 3'b010, 32'h10, 32'h00005555, 0);
    @(negedge clk);
    checks++; if (bus.c_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp_drop act=%0b exp=0", bus.c_rsp_valid); end
    checks++; if (bus.dm_wr !== 1'b0 || bus.c_req_ready !== 1'b0) begin failures++; $display("FAIL rm_wr_block act=%0b%0b exp=00", bus.dm_wr, bus.c_req_ready); end
    edge1();
    rst = 1'b0;
    checks++; if (bus.c_rsp_valid !== 1'b0) begin failures++; $display("FAIL rm_rsp_after act=%0b exp=0", bus.c_rsp_valid); end
    set_c(1, 0, 3'b010, 32'h10, 0, 0);
    edge1();
    checks++; if (bus.c_rsp_rdata !== 32'h0000ABCD) begin failures++; $display("FAIL rm_readback act=%h exp=0000abcd", bus.c_rsp_rdata); end
    set_c(0, 0, 3'b010, 0, 0, 0);
  endtask

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    set_c(1, 1, 3'b010, 32'h102, 32'hDEADBEEF, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1 || bus.dm_wr !== 1'b0) begin failures++; $display("FAIL al_sw_grant act=%0b%0b exp=10", bus.c_req_ready, bus.dm_wr); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b1 || bus.c_rsp_err !== 1'b1 || bus.c_rsp_rdata !== 32'h0) begin failures++; $display("FAIL al_sw_rsp act=%0b/%0b/%h exp=1/1/0", bus.c_rsp_valid, bus.c_rsp_err, bus.c_rsp_rdata); end
    set_c(1, 0, 3'b101, 32'h101, 0, 0);
    edge1();
    checks++; if (bus.c_rsp_err !== 1'b1 || bus.c_rsp_rdata !== 32'h0) begin failures++; $display("FAIL al_lhu_rsp act=%0b/%h exp=1/0", bus.c_rsp_err, bus.c_rsp_rdata); end
    set_c(1, 0, 3'b010, 32'h100, 0, 0);
    edge1();
    checks++; if (bus.c_rsp_err !== 1'b0 || bus.c_rsp_rdata !== 32'h11111111) begin failures++; $display("FAIL al_lw_old act=%0b/%h exp=0/11111111", bus.c_rsp_err, bus.c_rsp_rdata); end
    set_c(0, 0, 3'b010, 0, 0, 0);
  endtask
`else
  task automatic test_align();
    do_reset();
    set_c(1, 1, 3'b010, 32'h102, 32'hDEADBEEF, 0);
    @(negedge clk);
    checks++; if (bus.c_req_ready !== 1'b1 || bus.dm_wr !== 1'b1) begin failures++; $display("FAIL al_pass_grant act=%0b%0b exp=11", bus.c_req_ready, bus.dm_wr); end
    edge1();
    checks++; if (bus.c_rsp_valid !== 1'b1 || bus.c_rsp_err !== 1'b0) begin failures++; $display("FAIL al_pass_rsp act=%0b/%0b exp=1/0", bus.c_rsp_valid, bus.c_rsp_err); end
    set_c(0, 0, 3'b010, 0, 0, 0);
  endtask
`endif

  initial begin
    set_c(0, 0, 3'b010, 0, 0, 0);
    set_d(0, 0, 3'b010, 0, 0, 0);
    edge1();
    test_reset();
    test_store_load();
    test_round_robin();
    test_lock();
    test_forced_release();
    test_reset_mid();
    test_align();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
